// File: rtl/tfp2fix_pkg.sv
// Shared types and width helpers for the time-shared tfp2fix converter.
package tfp2fix_pkg;

  // Widest channel tag the tag pipe can carry; CW must not exceed it.
  localparam int TAG_CW = 8;

  typedef struct packed {
    logic              vld;
    logic [TAG_CW-1:0] chan;
  } tag_t;

  // Mantissa width plus the largest left shift the exponent can request.
  function automatic int fix_width(input int tfp_w, input int exp_w);
    return tfp_w - exp_w + (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/tfp2fix.sv
// Trivial-float to fixed converter: sign-extended mantissa << exponent, PIPELINE register stages.
module tfp2fix #(
  parameter int TFP_WIDTH = 8,
  parameter int EXP_WIDTH = 3,
  parameter int FIX_WIDTH = 12,
  parameter int PIPELINE  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkena,
  input  logic [TFP_WIDTH-1:0] tfp,
  output logic [FIX_WIDTH-1:0] fix
);

  logic signed [FIX_WIDTH-1:0]   mant;
  logic signed [FIX_WIDTH-1:0]   conv;
  logic [PIPELINE-1:0][FIX_WIDTH-1:0] stage;

  assign mant = FIX_WIDTH'($signed(tfp[TFP_WIDTH-1:EXP_WIDTH]));
  assign conv = mant <<< tfp[EXP_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage <= '0;
    else if (clkena) begin
      stage[0] <= conv;
      for (int i = 1; i < PIPELINE; i++) stage[i] <= stage[i-1];
    end
  end

  assign fix = stage[PIPELINE-1];

endmodule

// File: rtl/tfp2fix_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above ptr (with wrap) while adv.
module tfp2fix_rr_arb #(
  parameter int CHANNELS = 4,
  parameter int CW       = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                adv,
  output logic [CHANNELS-1:0] gnt,
  output logic [CW-1:0]       gidx,
  output logic                gvld
);

  logic [CW-1:0] ptr;
  logic [CW-1:0] idx;

  always_comb begin
    gnt  = '0;
    gidx = '0;
    gvld = 1'b0;
    idx  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = CW'((int'(ptr) + i) % CHANNELS);
      if (adv && !gvld && req[idx]) begin
        gvld     = 1'b1;
        gidx     = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  // A grant is always a transfer: gnt drives in_ready directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= '0;
    else if (gvld) ptr <= (gidx == CW'(CHANNELS-1)) ? '0 : gidx + CW'(1);
  end

endmodule

// File: rtl/tfp2fix_sched.sv
// Shares one pipelined tfp2fix among CHANNELS valid/ready sources; the channel tag rides alongside.
module tfp2fix_sched
  import tfp2fix_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int TFP_WIDTH = 8,
  parameter int EXP_WIDTH = 3,
  parameter int FIX_WIDTH = fix_width(TFP_WIDTH, EXP_WIDTH),
  parameter int PIPELINE  = 2,
  parameter int CW        = $clog2(CHANNELS)
) (
  input  logic                               rst,
  input  logic                               clk,
  input  logic [CHANNELS-1:0][TFP_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]                in_valid,
  output logic [CHANNELS-1:0]                in_ready,
  output logic [FIX_WIDTH-1:0]               out_data,
  output logic [CW-1:0]                      out_chan,
  output logic                               out_valid,
  input  logic                               out_ready
);

  if (PIPELINE < 1) begin : g_bad_pipeline
    $error("tfp2fix_sched: PIPELINE must be >= 1");
  end
  if (CHANNELS < 2 || CW > TAG_CW) begin : g_bad_channels
    $error("tfp2fix_sched: CHANNELS out of range");
  end

  tag_t [PIPELINE-1:0] tag_pipe;
  logic                en;
  logic                adv;
  logic                gvld;
  logic [CW-1:0]       gidx;
  logic                unused_chan_bits;

  assign out_valid        = tag_pipe[PIPELINE-1].vld;
  assign out_chan         = tag_pipe[PIPELINE-1].chan[CW-1:0];
  assign unused_chan_bits = ^tag_pipe[PIPELINE-1].chan;
  assign adv              = ~(out_valid & ~out_ready);

  // Holds off arbitration for one cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en <= 1'b0;
    else     en <= 1'b1;
  end

  tfp2fix_rr_arb #(.CHANNELS(CHANNELS), .CW(CW)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (in_valid & {CHANNELS{en}}),
    .adv  (adv),
    .gnt  (in_ready),
    .gidx (gidx),
    .gvld (gvld)
  );

  // Bubbles advance with the pipe and freeze with it; they are never squeezed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_pipe <= '0;
    else if (adv) begin
      tag_pipe[0] <= '{vld: gvld, chan: TAG_CW'(gidx)};
      for (int i = 1; i < PIPELINE; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  tfp2fix #(
    .TFP_WIDTH (TFP_WIDTH),
    .EXP_WIDTH (EXP_WIDTH),
    .FIX_WIDTH (FIX_WIDTH),
    .PIPELINE  (PIPELINE)
  ) u_conv (
    .clk    (clk),
    .rst    (rst),
    .clkena (adv),
    .tfp    (in_data[gidx]),
    .fix    (out_data)
  );

endmodule
